// File: rtl/pipe_control_unit_pkg.sv
// Shared constants for the pipelined control unit: opcode/func encodings,
// control-word layout and the branch-source / compare-code encodings.
package pipe_control_unit_pkg;

  // Control word layout {AluSrc, RegDst[1:0], MemRead, MemWrite, RegWrite, RegSrc[1:0]}
  localparam int CONTROL_SIZE   = 8;
  localparam int CB_ALU_SRC     = 7;
  localparam int CB_REG_DST_LO  = 5;
  localparam int CB_MEM_READ    = 4;
  localparam int CB_MEM_WRITE   = 3;
  localparam int CB_REG_WRITE   = 2;

  // Opcode and func encodings
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    CC_NONE   = 2'b00,
    CC_BEQ    = 2'b01,
    CC_BNE    = 2'b10,
    CC_UNCOND = 2'b11
  } cmp_code_e;

  typedef enum logic [1:0] {
    BS_PC_IMM = 2'b00,
    BS_IMM26  = 2'b01,
    BS_RS     = 2'b10
  } br_src_e;

  typedef enum logic [1:0] {
    RD_RD = 2'b00,
    RD_RT = 2'b01,
    RD_RA = 2'b10
  } reg_dst_e;

  // Pack the individual control fields into one control word
  function automatic logic [CONTROL_SIZE-1:0] make_ctrl(
    input logic       alu_src,
    input logic [1:0] reg_dst,
    input logic       mem_read,
    input logic       mem_write,
    input logic       reg_write,
    input logic [1:0] reg_src
  );
    return {alu_src, reg_dst, mem_read, mem_write, reg_write, reg_src};
  endfunction

endpackage

// File: rtl/pipe_control_unit_decode.sv
// ID-stage decoder: opcode/func -> control word, branch source, compare code,
// plus which source registers the instruction reads (used by the interlock).
module pipe_control_unit_decode
  import pipe_control_unit_pkg::*;
(
  input  logic                    i_id_valid,
  input  logic [5:0]              i_opcode,
  input  logic [5:0]              i_func,
  output logic [CONTROL_SIZE-1:0] o_ctrl,
  output logic [1:0]              o_branch_src,
  output logic [1:0]              o_compare_code,
  output logic                    o_reads_rs,
  output logic                    o_reads_rt,
  output logic                    o_is_branch
);

  // Decode table; an invalid ID slot decodes as an all-zero bubble
  always_comb begin
    o_ctrl         = '0;
    o_branch_src   = BS_PC_IMM;
    o_compare_code = CC_NONE;
    o_reads_rs     = 1'b0;
    o_reads_rt     = 1'b0;
    o_is_branch    = 1'b0;
    if (i_id_valid) begin
      o_reads_rs = 1'b1;
      case (i_opcode)
        OP_RTYPE: begin
          if (i_func == FN_JR) begin
            o_branch_src   = BS_RS;
            o_compare_code = CC_UNCOND;
            o_is_branch    = 1'b1;
          end else begin
            o_ctrl     = make_ctrl(1'b1, RD_RD, 1'b0, 1'b0, 1'b1, 2'b00);
            o_reads_rt = 1'b1;
          end
        end
        OP_J: begin
          o_reads_rs     = 1'b0;
          o_branch_src   = BS_IMM26;
          o_compare_code = CC_UNCOND;
        end
        OP_JAL: begin
          o_ctrl         = make_ctrl(1'b0, RD_RA, 1'b0, 1'b0, 1'b1, 2'b10);
          o_reads_rs     = 1'b0;
          o_branch_src   = BS_IMM26;
          o_compare_code = CC_UNCOND;
        end
        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
          o_ctrl = make_ctrl(1'b0, RD_RT, 1'b0, 1'b0, 1'b1, 2'b00);
        end
        OP_LW: begin
          o_ctrl = make_ctrl(1'b0, RD_RT, 1'b1, 1'b0, 1'b1, 2'b01);
        end
        OP_SW: begin
          o_ctrl     = make_ctrl(1'b0, RD_RD, 1'b0, 1'b1, 1'b0, 2'b00);
          o_reads_rt = 1'b1;
        end
        OP_BEQ: begin
          o_compare_code = CC_BEQ;
          o_reads_rt     = 1'b1;
          o_is_branch    = 1'b1;
        end
        OP_BNE: begin
          o_compare_code = CC_BNE;
          o_reads_rt     = 1'b1;
          o_is_branch    = 1'b1;
        end
        default: begin
          o_ctrl = '0;
        end
      endcase
    end else begin
      o_ctrl = '0;
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes in ID and carries control/dst through the
// ID/EX, EX/MEM and MEM/WB registers, with interlock, IF flush and memory freeze.
// Optional feature: define HAZARD_STALL_EN to enable the load-use / branch-operand
// interlock; without it only mem_busy stalls and software schedules NOPs.
module pipe_control_unit
  import pipe_control_unit_pkg::*;
#(
  parameter int CTRL_W     = 8,
  parameter int REG_ADDR_W = 5,
  parameter int RA_REG     = 31,
  parameter int DELAY_SLOT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [5:0]            i_opcode,
  input  logic [5:0]            i_func,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_busy,
  output logic [1:0]            o_branch_src,
  output logic [1:0]            o_compare_code,
  output logic [2:0]            o_ex_ctrl,
  output logic [1:0]            o_mem_ctrl,
  output logic [2:0]            o_wb_ctrl,
  output logic [REG_ADDR_W-1:0] o_ex_dst,
  output logic [REG_ADDR_W-1:0] o_mem_dst,
  output logic [REG_ADDR_W-1:0] o_wb_dst,
  output logic                  o_stall_if_id,
  output logic                  o_flush_if_id
);

  localparam bit FLUSH_EN = (DELAY_SLOT == 32'sd0);

  logic [CTRL_W-1:0]       w_id_ctrl;
  logic [1:0]              w_branch_src;
  logic [1:0]              w_compare_code;
  logic                    w_reads_rs;
  logic                    w_reads_rt;
  logic                    w_is_branch;
  logic [REG_ADDR_W-1:0]   w_dst_sel;
  logic [REG_ADDR_W-1:0]   w_id_dst;
  logic                    w_hazard;
  logic                    w_stall;
  logic                    w_flush;

  logic [CTRL_W-1:0]       r_ex_ctrl;
  logic [REG_ADDR_W-1:0]   r_ex_dst;
  logic [CB_MEM_READ:0]    r_mem_ctrl;
  logic [REG_ADDR_W-1:0]   r_mem_dst;
  logic [CB_REG_WRITE:0]   r_wb_ctrl;
  logic [REG_ADDR_W-1:0]   r_wb_dst;

  pipe_control_unit_decode u_decode (
    .i_id_valid     (i_id_valid),
    .i_opcode       (i_opcode),
    .i_func         (i_func),
    .o_ctrl         (w_id_ctrl),
    .o_branch_src   (w_branch_src),
    .o_compare_code (w_compare_code),
    .o_reads_rs     (w_reads_rs),
    .o_reads_rt     (w_reads_rt),
    .o_is_branch    (w_is_branch)
  );

  // Destination select from RegDst; instructions that do not write get dst 0
  always_comb begin
    w_dst_sel = '0;
    case (w_id_ctrl[CB_REG_DST_LO +: 2])
      RD_RD:   w_dst_sel = i_rd;
      RD_RT:   w_dst_sel = i_rt;
      RD_RA:   w_dst_sel = REG_ADDR_W'(RA_REG);
      default: w_dst_sel = '0;
    endcase
    if (w_id_ctrl[CB_REG_WRITE]) begin
      w_id_dst = w_dst_sel;
    end else begin
      w_id_dst = '0;
    end
  end

`ifdef HAZARD_STALL_EN
  // True when register r is actually read and matches a writing producer
  function automatic logic reg_hit(
    input logic                  rd_en,
    input logic [REG_ADDR_W-1:0] r,
    input logic                  wr_en,
    input logic [REG_ADDR_W-1:0] dst
  );
    return rd_en && (r != '0) && wr_en && (dst == r);
  endfunction

  logic w_ex_hit;
  logic w_mem_hit;

  // Interlock: load-use against EX, branch/JR operands against EX and a load in MEM
  always_comb begin
    w_ex_hit  = reg_hit(w_reads_rs, i_rs, r_ex_ctrl[CB_REG_WRITE], r_ex_dst) |
                reg_hit(w_reads_rt, i_rt, r_ex_ctrl[CB_REG_WRITE], r_ex_dst);
    w_mem_hit = reg_hit(w_reads_rs, i_rs, r_mem_ctrl[CB_REG_WRITE], r_mem_dst) |
                reg_hit(w_reads_rt, i_rt, r_mem_ctrl[CB_REG_WRITE], r_mem_dst);
    w_hazard  = (r_ex_ctrl[CB_MEM_READ] & w_ex_hit) |
                (w_is_branch & w_ex_hit) |
                (w_is_branch & r_mem_ctrl[CB_MEM_READ] & w_mem_hit);
  end
`else
  logic w_unused_hazard;
  assign w_unused_hazard = ^{i_rs, i_rt, w_reads_rs, w_reads_rt, w_is_branch};
  assign w_hazard        = 1'b0;
`endif

  // Stall and flush requests for the IF/ID register, both cleared while in reset
  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    if (i_reset) begin
      w_stall = 1'b0;
      w_flush = 1'b0;
    end else begin
      w_stall = i_mem_busy | w_hazard;
      if (FLUSH_EN && !w_stall) begin
        w_flush = (w_compare_code == CC_UNCOND) |
                  (((w_compare_code == CC_BEQ) | (w_compare_code == CC_BNE)) & i_branch_taken);
      end else begin
        w_flush = 1'b0;
      end
    end
  end

  // Stage registers: reset clears, mem_busy freezes, hazard injects an ID/EX bubble
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_ctrl  <= '0;
      r_ex_dst   <= '0;
      r_mem_ctrl <= '0;
      r_mem_dst  <= '0;
      r_wb_ctrl  <= '0;
      r_wb_dst   <= '0;
    end else if (i_mem_busy) begin
      r_ex_ctrl  <= r_ex_ctrl;
      r_ex_dst   <= r_ex_dst;
      r_mem_ctrl <= r_mem_ctrl;
      r_mem_dst  <= r_mem_dst;
      r_wb_ctrl  <= r_wb_ctrl;
      r_wb_dst   <= r_wb_dst;
    end else begin
      if (w_hazard) begin
        r_ex_ctrl <= '0;
        r_ex_dst  <= '0;
      end else begin
        r_ex_ctrl <= w_id_ctrl;
        r_ex_dst  <= w_id_dst;
      end
      r_mem_ctrl <= r_ex_ctrl[CB_MEM_READ:0];
      r_mem_dst  <= r_ex_dst;
      r_wb_ctrl  <= r_mem_ctrl[CB_REG_WRITE:0];
      r_wb_dst   <= r_mem_dst;
    end
  end

  assign o_branch_src   = w_branch_src;
  assign o_compare_code = w_compare_code;
  assign o_ex_ctrl      = r_ex_ctrl[CB_ALU_SRC -: 3];
  assign o_mem_ctrl     = r_mem_ctrl[CB_MEM_READ:CB_MEM_WRITE];
  assign o_wb_ctrl      = r_wb_ctrl;
  assign o_ex_dst       = r_ex_dst;
  assign o_mem_dst      = r_mem_dst;
  assign o_wb_dst       = r_wb_dst;
  assign o_stall_if_id  = w_stall;
  assign o_flush_if_id  = w_flush;

endmodule
